sync_fifo_vr: RTL and testbench

- Small synchronous FIFO with valid/ready handshake on both sides.
- Decouples a producer from a consumer in gate-level timing-study designs.
- RTL is written to synthesize onto the team's CMOS cell set: BUF, NOT, NAND, NAND3, NOR, NOR3, DFF, DFFSR.
- Async-reset flops map to DFFSR; storage flops map to plain DFF.

---
 rtl/sync_fifo_vr_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 18 +
 rtl/sync_fifo_vr.sv | 59 +++++
 tb/tb_sync_fifo_vr.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_vr_pkg.sv
// sync_fifo_vr_pkg: shared defaults, fill-state type and clog2 helper for the FIFO.
package sync_fifo_vr_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: unreset DEPTH x WIDTH register file, sync write, async read.
// Ports: C clock; we/waddr/wdata write port; raddr -> rdata combinational read.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int AW = 2
) (
  input  logic             C,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge C)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: first-word fall-through FIFO with valid/ready on both sides.
// Ports: C clock; RN async active-low reset; flush sync clear;
//   in_data/in_valid/in_ready producer side; out_data/out_valid/out_ready consumer side;
//   count stored entries 0..DEPTH; ovf_err sticky write-while-full flag.
module sync_fifo_vr
  import sync_fifo_vr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  C,
  input  logic                  RN,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] count,
  output logic                  ovf_err
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic push, pop;
  fill_e fill;
  // Handshake flags come from count alone, so neither side sees a combinational path from the other.
  always_comb begin
    fill = count == '0 ? EMPTY : count == FULL_CNT ? FULL : PARTIAL;
    in_ready = fill != FULL;
    out_valid = fill != EMPTY;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    out_data = out_valid ? rdata : '0;
  end
  sync_fifo_mem #(.WIDTH(WIDTH), .AW(AW)) u_mem (
    .C(C), .we(push), .waddr(wr_ptr), .wdata(in_data), .raddr(rd_ptr), .rdata(rdata)
  );
  always_ff @(posedge C or negedge RN)
    if (!RN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      // A pop in the same cycle means the producer is merely early, not overflowing.
      if (in_valid && fill == FULL && !pop) ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_sync_fifo_vr.sv
// tb_sync_fifo_vr: directed scenarios plus randomized run against a queue model.
module tb_sync_fifo_vr;
  localparam int W = 8;
  localparam int D = 4;
  logic C = 1'b0;
  logic RN = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, ovf_err;
  logic [W-1:0] out_data;
  logic [2:0] count;
  int errors = 0;
  int checks = 0;

  always #5 C = ~C;

  sync_fifo_vr #(.WIDTH(W), .DEPTH(D)) dut (
    .C(C), .RN(RN), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .ovf_err(ovf_err)
  );

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic test_reset;
    RN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = i[0];
      in_data = 8'hEE;
      tick;
      checks++;
      if ({in_ready, out_valid, count, ovf_err, out_data} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL reset_state got rdy=%b vld=%b cnt=%0d ovf=%b data=%h exp rdy=1 vld=0 cnt=0 ovf=0 data=00",
                 in_ready, out_valid, count, ovf_err, out_data);
      end
    end
    in_valid = 1'b0;
    RN = 1'b1;
    tick;
    in_valid = 1'b1;
    in_data = 8'h01;
    tick;
    in_data = 8'h02;
    tick;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL reset_pre_count got=%0d exp=2", count);
    end
    #3 RN = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got cnt=%0d vld=%b data=%h exp cnt=0 vld=0 data=00", count, out_valid, out_data);
    end
    #1 RN = 1'b1;
    tick;
  endtask

  task automatic test_order;
    logic [W-1:0] exp [3];
    exp[0] = 8'hA1;
    exp[1] = 8'hB2;
    exp[2] = 8'hC3;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_empty_valid got=%b exp=0", out_valid);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = exp[i];
      tick;
      checks++;
      if (count !== 3'(i + 1) || out_valid !== 1'b1 || out_data !== 8'hA1) begin
        errors++;
        $display("FAIL order_fill[%0d] got cnt=%0d vld=%b data=%h exp cnt=%0d vld=1 data=a1",
                 i, count, out_valid, out_data, i + 1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== exp[i]) begin
        errors++;
        $display("FAIL order_data[%0d] got=%h exp=%h", i, out_data, exp[i]);
      end
      tick;
      checks++;
      if (count !== 3'(2 - i)) begin
        errors++;
        $display("FAIL order_drain_count[%0d] got=%0d exp=%0d", i, count, 2 - i);
      end
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL order_empty got vld=%b data=%h exp vld=0 data=00", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL order_pop_empty got=%0d exp=0", count);
    end
  endtask

  task automatic test_full;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      tick;
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL full_state got cnt=%0d rdy=%b ovf=%b exp cnt=4 rdy=0 ovf=0", count, in_ready, ovf_err);
    end
    in_data = 8'h99;
    tick;
    in_valid = 1'b0;
    checks++;
    if (ovf_err !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL full_ovf got ovf=%b cnt=%0d exp ovf=1 cnt=4", ovf_err, count);
    end
    tick;
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL full_ovf_sticky got=%b exp=1", ovf_err);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL full_drain[%0d] got=%h exp=%h", i, out_data, 8'h10 + 8'(i));
      end
      tick;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL full_after_drain got vld=%b cnt=%0d exp vld=0 cnt=0", out_valid, count);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL full_flush_ovf got=%b exp=0", ovf_err);
    end
  endtask

  task automatic test_simul;
    logic [W-1:0] rest [3];
    rest[0] = 8'h03;
    rest[1] = 8'h04;
    rest[2] = 8'h05;
    in_valid = 1'b1;
    in_data = 8'h01;
    tick;
    in_data = 8'h02;
    tick;
    in_data = 8'h03;
    out_ready = 1'b1;
    tick;
    checks++;
    if (count !== 3'd2 || out_data !== 8'h02) begin
      errors++;
      $display("FAIL simul_partial got cnt=%0d data=%h exp cnt=2 data=02", count, out_data);
    end
    out_ready = 1'b0;
    in_data = 8'h04;
    tick;
    in_data = 8'h05;
    tick;
    in_data = 8'hAA;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL simul_full_pre got rdy=%b cnt=%0d exp rdy=0 cnt=4", in_ready, count);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3 || out_data !== 8'h03 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_full got cnt=%0d data=%h ovf=%b exp cnt=3 data=03 ovf=0", count, out_data, ovf_err);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== rest[i]) begin
        errors++;
        $display("FAIL simul_drain[%0d] got=%h exp=%h", i, out_data, rest[i]);
      end
      tick;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i) || count !== 3'd1) begin
        errors++;
        $display("FAIL wrap[%0d] got vld=%b data=%h cnt=%0d exp vld=1 data=%h cnt=1", i, out_valid, out_data, count, 8'(i));
      end
    end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_end got=%0d exp=0", count);
    end
  endtask

  task automatic test_flush;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h21 + 8'(i);
      tick;
    end
    in_data = 8'h55;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || ovf_err !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL flush_clear got cnt=%0d vld=%b ovf=%b data=%h exp cnt=0 vld=0 ovf=0 data=00",
               count, out_valid, ovf_err, out_data);
    end
    in_valid = 1'b1;
    in_data = 8'h66;
    tick;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_data !== 8'h66) begin
      errors++;
      $display("FAIL flush_next got cnt=%0d data=%h exp cnt=1 data=66", count, out_data);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [W-1:0] q [$];
    logic ovf_m;
    logic full_m, push_m, pop_m;
    logic [W-1:0] head;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_data = 8'($urandom);
      full_m = q.size() == D;
      push_m = in_valid && !full_m;
      pop_m = out_ready && q.size() > 0;
      if (flush) begin
        q.delete();
        ovf_m = 1'b0;
      end else begin
        if (in_valid && full_m && !pop_m) ovf_m = 1'b1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(in_data);
      end
      tick;
      head = q.size() > 0 ? q[0] : 8'h00;
      checks++;
      if (int'(count) != q.size()) begin
        errors++;
        $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, count, q.size());
      end
      checks++;
      if ({out_valid, in_ready, ovf_err, out_data} !== {q.size() > 0, q.size() < D, ovf_m, head}) begin
        errors++;
        $display("FAIL rand_out[%0d] got vld=%b rdy=%b ovf=%b data=%h exp vld=%b rdy=%b ovf=%b data=%h",
                 n, out_valid, in_ready, ovf_err, out_data, q.size() > 0, q.size() < D, ovf_m, head);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #2;
    test_reset;
    test_order;
    test_full;
    test_simul;
    test_wrap;
    test_flush;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
